// File: rtl/aim_camera_ctrl_if.sv
// aim_camera_ctrl_if: video timing, aim buttons, ball samples in; published camera out.
interface aim_camera_ctrl_if;
  logic [10:0] hcount_in;
  logic [9:0] vcount_in;
  logic left_in;
  logic right_in;
  logic aim_en_in;
  logic [15:0] ball_x_in;
  logic [15:0] ball_y_in;
  logic ball_valid_in;
  logic [15:0] ballx_out;
  logic [15:0] bally_out;
  logic [15:0] angle_out;
  logic frame_update_out;
  modport slave (
    input hcount_in, vcount_in, left_in, right_in, aim_en_in, ball_x_in, ball_y_in, ball_valid_in,
    output ballx_out, bally_out, angle_out, frame_update_out
  );
  modport master (
    output hcount_in, vcount_in, left_in, right_in, aim_en_in, ball_x_in, ball_y_in, ball_valid_in,
    input ballx_out, bally_out, angle_out, frame_update_out
  );
endinterface

// File: rtl/aim_camera_ctrl.sv
// aim_camera_ctrl: frame-synchronous camera heading/position publisher for the ground renderer.
module aim_camera_ctrl #(
  parameter int STEP_DEG = 1,
  parameter int HOLD_DELAY = 20,
  parameter int REPEAT_PERIOD = 3,
  parameter int INIT_ANGLE = 90,
  parameter int ACTIVE_H = 1280,
  parameter int ACTIVE_V = 720
) (
  input logic pixel_clk_in,
  input logic rst_n_in,
  aim_camera_ctrl_if.slave bus
);
  localparam int MAXC = HOLD_DELAY > REPEAT_PERIOD ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [8:0] S9 = 9'(STEP_DEG);
  localparam logic [8:0] A0 = 9'(INIT_ANGLE);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  if (STEP_DEG < 1 || STEP_DEG > 359) begin : g_bad_step
    $error("STEP_DEG must be 1..359");
  end
  if (HOLD_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_timing
    $error("HOLD_DELAY and REPEAT_PERIOD must be >= 1");
  end
  if (INIT_ANGLE < 0 || INIT_ANGLE > 359) begin : g_bad_init
    $error("INIT_ANGLE must be 0..359");
  end
  if (ACTIVE_H < 1 || ACTIVE_H > 2047 || ACTIVE_V < 1 || ACTIVE_V > 1023) begin : g_bad_raster
    $error("ACTIVE_H/ACTIVE_V exceed the timing counter widths");
  end
  logic [1:0] rst_q;
  logic rst_n;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc, lim;
  logic [1:0] dir, dir_q, dir_n;
  logic [8:0] ang, ang_n, ang_inc, ang_dec;
  logic [9:0] sum;
  logic [15:0] sh_x, sh_y;
  logic fs, step;
  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_q <= 2'b00;
    else rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_n = rst_q[1];
  assign fs = bus.hcount_in == 11'd0 && bus.vcount_in == 10'(ACTIVE_V);
  assign dir = {bus.right_in & ~bus.left_in, bus.left_in & ~bus.right_in};
  assign cnt_inc = cnt + 1'b1;
  assign lim = state == HOLD ? CW'(HOLD_DELAY) : CW'(REPEAT_PERIOD);
  assign sum = {1'b0, ang} + {1'b0, S9};
  assign ang_inc = sum >= 10'd360 ? 9'(sum - 10'd360) : sum[8:0];
  assign ang_dec = ang < S9 ? 9'({1'b0, ang} + 10'd360 - {1'b0, S9}) : ang - S9;
  assign ang_n = step ? (dir_n[0] ? ang_inc : ang_dec) : ang;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dir_n = dir_q;
    step = 1'b0;
    if (fs) begin
      if (state == IDLE) begin
        if (dir != 2'b00 && bus.aim_en_in) begin
          step = 1'b1;
          cnt_n = '0;
          dir_n = dir;
          state_n = HOLD;
        end
      end else if (dir == 2'b00 || !bus.aim_en_in) begin
        cnt_n = '0;
        state_n = IDLE;
      end else if (dir != dir_q) begin
        step = 1'b1;
        cnt_n = '0;
        dir_n = dir;
        state_n = HOLD;
      end else if (cnt_inc == lim) begin
        step = 1'b1;
        cnt_n = '0;
        state_n = REPEAT;
      end else begin
        cnt_n = cnt_inc;
      end
    end
  end
  always_ff @(posedge pixel_clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      dir_q <= 2'b00;
      ang <= A0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dir_q <= dir_n;
      ang <= ang_n;
    end
  end
  // Outputs load on the fs edge, so a sample arriving with fs lands one frame later.
  always_ff @(posedge pixel_clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sh_x <= '0;
      sh_y <= '0;
      bus.ballx_out <= '0;
      bus.bally_out <= '0;
      bus.angle_out <= {7'd0, A0};
      bus.frame_update_out <= 1'b0;
    end else begin
      if (bus.ball_valid_in) begin
        sh_x <= bus.ball_x_in;
        sh_y <= bus.ball_y_in;
      end
      if (fs) begin
        bus.ballx_out <= sh_x;
        bus.bally_out <= sh_y;
        bus.angle_out <= {7'd0, ang_n};
      end
      bus.frame_update_out <= fs;
    end
  end
endmodule

// File: tb/tb_aim_camera_ctrl.sv
// tb_aim_camera_ctrl: scoreboard bench on a shrunken raster; four DUTs cover parameter corners.
module tb_aim_camera_ctrl;
  localparam int HT = 20, VT = 16, AH = 16, AV = 12;
  typedef struct packed {logic [15:0] x, y, a;} exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [10:0] h;
  logic [9:0] v;
  logic left, right, en, bv;
  logic [15:0] bx, by;
  exp_t q[$];
  exp_t e;
  int total = 0, fails = 0;
  int m_ang, m_n, m_dir;
  logic [15:0] m_x, m_y;
  always #5 clk = ~clk;
  aim_camera_ctrl_if ifs[4]();
  for (genvar g = 0; g < 4; g++) begin : g_drv
    assign ifs[g].hcount_in = h;
    assign ifs[g].vcount_in = v;
    assign ifs[g].left_in = left;
    assign ifs[g].right_in = right;
    assign ifs[g].aim_en_in = en;
    assign ifs[g].ball_x_in = bx;
    assign ifs[g].ball_y_in = by;
    assign ifs[g].ball_valid_in = bv;
  end
  aim_camera_ctrl #(.ACTIVE_H(AH), .ACTIVE_V(AV)) d0 (.pixel_clk_in(clk), .rst_n_in(rst_n), .bus(ifs[0]));
  aim_camera_ctrl #(.INIT_ANGLE(359), .ACTIVE_H(AH), .ACTIVE_V(AV)) d1 (.pixel_clk_in(clk), .rst_n_in(rst_n), .bus(ifs[1]));
  aim_camera_ctrl #(.INIT_ANGLE(0), .ACTIVE_H(AH), .ACTIVE_V(AV)) d2 (.pixel_clk_in(clk), .rst_n_in(rst_n), .bus(ifs[2]));
  aim_camera_ctrl #(.STEP_DEG(5), .INIT_ANGLE(357), .ACTIVE_H(AH), .ACTIVE_V(AV)) d3 (.pixel_clk_in(clk), .rst_n_in(rst_n), .bus(ifs[3]));
  initial begin
    h = '0;
    v = '0;
    forever begin
      @(posedge clk);
      #1;
      if (h == 11'(HT - 1)) begin
        h = '0;
        v = v == 10'(VT - 1) ? '0 : v + 10'd1;
      end else h = h + 11'd1;
    end
  end
  task automatic model_reset();
    m_ang = 90;
    m_n = 0;
    m_dir = 0;
    m_x = '0;
    m_y = '0;
    q.delete();
  endtask
  // Held-frame count n: step on the first frame, then every 3rd frame once n passes 20.
  task automatic model_fs();
    int d = (left && !right) ? 1 : (right && !left) ? -1 : 0;
    if (d == 0 || !en) m_n = 0;
    else if (m_n == 0 || d != m_dir) begin
      m_n = 1;
      m_dir = d;
    end else m_n++;
    if (m_n == 1 || (m_n > 20 && (m_n - 21) % 3 == 0)) m_ang = (m_ang + d + 360) % 360;
  endtask
  task automatic goto_fs();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(h == 0 && v == 10'(AV)) && k < 2 * HT * VT);
    if (!(h == 0 && v == 10'(AV))) begin
      total++;
      fails++;
      $display("FAIL fs_timeout: no frame strobe within %0d cycles", k);
    end
  endtask
  task automatic goto_line(input int line);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(v == 10'(line) && h == 11'd5) && k < 2 * HT * VT);
    if (!(v == 10'(line) && h == 11'd5)) begin
      total++;
      fails++;
      $display("FAIL line_timeout: line %0d not reached", line);
    end
  endtask
  task automatic fs_push();
    goto_fs();
    model_fs();
    q.push_back(exp_t'{m_x, m_y, 16'(m_ang)});
  endtask
  task automatic frame();
    fs_push();
    @(negedge clk);
  endtask
  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    total++;
    if ({ifs[0].ballx_out, ifs[0].bally_out, ifs[0].angle_out, ifs[0].frame_update_out} !== {16'h0, 16'h0, 16'd90, 1'b0}) begin
      fails++;
      $display("FAIL reset_d0: got x=%h y=%h a=%0d upd=%b, want 0 0 90 0", ifs[0].ballx_out, ifs[0].bally_out, ifs[0].angle_out, ifs[0].frame_update_out);
    end
    total++;
    if ({ifs[1].angle_out, ifs[2].angle_out, ifs[3].angle_out} !== {16'd359, 16'd0, 16'd357}) begin
      fails++;
      $display("FAIL reset_init: got %0d %0d %0d, want 359 0 357", ifs[1].angle_out, ifs[2].angle_out, ifs[3].angle_out);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_idle_frames();
    for (int i = 0; i < 2; i++) begin
      fs_push();
      total++;
      if (ifs[0].frame_update_out !== 1'b0) begin
        fails++;
        $display("FAIL idle_upd_early f%0d: got %b, want 0", i, ifs[0].frame_update_out);
      end
      @(negedge clk);
      e = q.pop_front();
      total++;
      if ({ifs[0].ballx_out, ifs[0].bally_out, ifs[0].angle_out} !== e) begin
        fails++;
        $display("FAIL idle_pub f%0d: got %h/%h/%0d, want %h/%h/%0d", i, ifs[0].ballx_out, ifs[0].bally_out, ifs[0].angle_out, e.x, e.y, e.a);
      end
      total++;
      if (ifs[0].frame_update_out !== 1'b1) begin
        fails++;
        $display("FAIL idle_upd_pulse f%0d: got %b, want 1", i, ifs[0].frame_update_out);
      end
      @(negedge clk);
      total++;
      if (ifs[0].frame_update_out !== 1'b0) begin
        fails++;
        $display("FAIL idle_upd_width f%0d: got %b, want 0", i, ifs[0].frame_update_out);
      end
    end
  endtask
  task automatic test_position();
    goto_line(3);
    bx = 16'h1234;
    by = 16'h0ABC;
    bv = 1'b1;
    m_x = bx;
    m_y = by;
    @(negedge clk);
    bv = 1'b0;
    total++;
    if ({ifs[0].ballx_out, ifs[0].bally_out} !== 32'h0) begin
      fails++;
      $display("FAIL pos_held: got %h/%h, want 0000/0000", ifs[0].ballx_out, ifs[0].bally_out);
    end
    frame();
    e = q.pop_front();
    total++;
    if ({ifs[0].ballx_out, ifs[0].bally_out, ifs[0].angle_out} !== e || ifs[0].ballx_out !== 16'h1234) begin
      fails++;
      $display("FAIL pos_pub: got %h/%h/%0d, want %h/%h/%0d", ifs[0].ballx_out, ifs[0].bally_out, ifs[0].angle_out, e.x, e.y, e.a);
    end
    fs_push();
    bx = 16'h5555;
    by = 16'h6666;
    bv = 1'b1;
    @(negedge clk);
    bv = 1'b0;
    m_x = 16'h5555;
    m_y = 16'h6666;
    e = q.pop_front();
    total++;
    if ({ifs[0].ballx_out, ifs[0].bally_out, ifs[0].angle_out} !== e) begin
      fails++;
      $display("FAIL pos_coincident: got %h/%h/%0d, want %h/%h/%0d", ifs[0].ballx_out, ifs[0].bally_out, ifs[0].angle_out, e.x, e.y, e.a);
    end
    frame();
    e = q.pop_front();
    total++;
    if ({ifs[0].ballx_out, ifs[0].bally_out, ifs[0].angle_out} !== e) begin
      fails++;
      $display("FAIL pos_deferred: got %h/%h/%0d, want %h/%h/%0d", ifs[0].ballx_out, ifs[0].bally_out, ifs[0].angle_out, e.x, e.y, e.a);
    end
  endtask
  task automatic test_wrap();
    apply_reset();
    left = 1'b1;
    frame();
    left = 1'b0;
    e = q.pop_front();
    total++;
    if ({ifs[0].angle_out, ifs[1].angle_out, ifs[2].angle_out, ifs[3].angle_out} !== {e.a, 16'd0, 16'd1, 16'd2}) begin
      fails++;
      $display("FAIL wrap_up: got %0d %0d %0d %0d, want %0d 0 1 2", ifs[0].angle_out, ifs[1].angle_out, ifs[2].angle_out, ifs[3].angle_out, e.a);
    end
    apply_reset();
    right = 1'b1;
    frame();
    right = 1'b0;
    e = q.pop_front();
    total++;
    if ({ifs[0].angle_out, ifs[1].angle_out, ifs[2].angle_out, ifs[3].angle_out} !== {e.a, 16'd358, 16'd359, 16'd352}) begin
      fails++;
      $display("FAIL wrap_down: got %0d %0d %0d %0d, want %0d 358 359 352", ifs[0].angle_out, ifs[1].angle_out, ifs[2].angle_out, ifs[3].angle_out, e.a);
    end
  endtask
  task automatic test_hold_repeat();
    apply_reset();
    left = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      frame();
      e = q.pop_front();
      total++;
      if (ifs[0].angle_out !== e.a) begin
        fails++;
        $display("FAIL hold_repeat f%0d: got %0d, want %0d", i, ifs[0].angle_out, e.a);
      end
    end
    left = 1'b0;
    total++;
    if (ifs[0].angle_out !== 16'd95) begin
      fails++;
      $display("FAIL hold_repeat_final: got %0d, want 95", ifs[0].angle_out);
    end
  endtask
  task automatic test_no_step();
    apply_reset();
    left = 1'b1;
    right = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      if (i == 11) begin
        right = 1'b0;
        en = 1'b0;
      end
      frame();
      e = q.pop_front();
      total++;
      if (ifs[0].angle_out !== e.a || ifs[0].angle_out !== 16'd90) begin
        fails++;
        $display("FAIL no_step f%0d: got %0d, want %0d", i, ifs[0].angle_out, e.a);
      end
    end
    left = 1'b0;
    en = 1'b1;
  endtask
  task automatic test_reversal();
    apply_reset();
    left = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) begin
        left = 1'b0;
        right = 1'b1;
      end
      frame();
      e = q.pop_front();
      total++;
      if (ifs[0].angle_out !== e.a || ifs[0].angle_out !== (i == 6 ? 16'd90 : 16'd91)) begin
        fails++;
        $display("FAIL reversal f%0d: got %0d, want %0d", i, ifs[0].angle_out, e.a);
      end
    end
    right = 1'b0;
  endtask
  task automatic test_reset_mid_repeat();
    apply_reset();
    left = 1'b1;
    repeat (25) begin
      frame();
      e = q.pop_front();
    end
    total++;
    if (ifs[0].angle_out !== 16'd93) begin
      fails++;
      $display("FAIL pre_reset_angle: got %0d, want 93", ifs[0].angle_out);
    end
    goto_line(5);
    rst_n = 1'b0;
    #1;
    total++;
    if ({ifs[0].ballx_out, ifs[0].bally_out, ifs[0].angle_out, ifs[0].frame_update_out} !== {16'h0, 16'h0, 16'd90, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: got %h/%h/%0d upd=%b, want 0/0/90 0", ifs[0].ballx_out, ifs[0].bally_out, ifs[0].angle_out, ifs[0].frame_update_out);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      frame();
      e = q.pop_front();
      total++;
      if (ifs[0].angle_out !== e.a) begin
        fails++;
        $display("FAIL post_reset f%0d: got %0d, want %0d", i, ifs[0].angle_out, e.a);
      end
    end
    left = 1'b0;
  endtask
  initial begin
    left = 1'b0;
    right = 1'b0;
    en = 1'b1;
    bv = 1'b0;
    bx = '0;
    by = '0;
    test_reset();
    test_idle_frames();
    test_position();
    test_wrap();
    test_hold_repeat();
    test_no_step();
    test_reversal();
    test_reset_mid_repeat();
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
